load_store_unit: RTL and testbench

- Multi-cycle data-side access unit, directly downstream of the single-cycle core's execute stage.
- Consumes the core's ALU-computed address, store data and funct3.
- Performs RV32I byte/halfword/word sizing, alignment checking and a valid/ready handshake to data memory.
- Stalls the core until the access completes, then returns the sign- or zero-extended load data for writeback.

---
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// Handshake: mem_req is held with stable mem_we/mem_addr/mem_be/mem_wdata until mem_ready is
// sampled high on a rising edge; that edge completes the transfer (mem_rdata is valid with mem_ready).
interface load_store_unit_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I data-side access unit: sizes, checks and issues one load/store to data memory,
// stalling the core until completion and returning extended load data for writeback.
module load_store_unit #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [1:0]        dbg_state,
    load_store_unit_if.master mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [7:0]        cnt;
    logic [1:0]        code_q;
    logic [31:0]       rdata_q;

    logic              illegal, misaligned, timeout_hit;
    logic [1:0]        req_code;
    logic [1:0]        lane;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       shifted;
    logic [31:0]       load_data;

    // Illegal funct3 wins over misalignment when both apply.
    always_comb begin
        illegal    = req_we ? !(funct3 inside {3'b000, 3'b001, 3'b010})
                            : !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        req_code   = illegal ? 2'b10 : (misaligned ? 2'b01 : 2'b00);
    end

    assign timeout_hit = (state == BUSY) && !mem.mem_ready &&
                         (cnt == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        lane    = addr_q[1:0];
        shifted = mem.mem_rdata >> {lane, 3'b000};
        case (f3_q[1:0])
            2'b00:   begin lane_be = 4'b0001 << lane; lane_wdata = {4{wdata_q[7:0]}};  end
            2'b01:   begin lane_be = 4'b0011 << lane; lane_wdata = {2{wdata_q[15:0]}}; end
            default: begin lane_be = 4'b1111;         lane_wdata = wdata_q;            end
        endcase
        case (f3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = mem.mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Outputs decode from state; reset also masks the combinational IDLE stall.
    always_comb begin
        state_nxt     = state;
        stall         = 1'b0;
        rdata_valid   = 1'b0;
        err           = 1'b0;
        err_code      = 2'b00;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_be    = 4'b0000;
        mem.mem_wdata = 32'd0;
        case (state)
            IDLE: begin
                stall = req_valid & rst;
                if (req_valid) state_nxt = (req_code != 2'b00) ? DONE : BUSY;
            end
            BUSY: begin
                stall         = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = we_q;
                mem.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem.mem_be    = lane_be;
                mem.mem_wdata = lane_wdata;
                if (mem.mem_ready || timeout_hit) state_nxt = DONE;
            end
            DONE: begin
                err         = (code_q != 2'b00);
                err_code    = code_q;
                rdata_valid = !we_q && (code_q == 2'b00);
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            cnt     <= 8'd0;
            code_q  <= 2'b00;
            rdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= funct3;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        code_q  <= req_code;
                    end
                end
                BUSY: begin
                    if (mem.mem_ready) begin
                        cnt <= 8'd0;
                        if (!we_q) rdata_q <= load_data;
                    end else if (timeout_hit) begin
                        cnt     <= 8'd0;
                        code_q  <= 2'b11;
                        rdata_q <= 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses
// checked against a behavioural model of sizing, faults, latency and load extension.
module tb_load_store_unit;

    localparam int ADDR_W = 16;
    localparam int TO     = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              req_valid, req_we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              stall, rdata_valid, err;
    logic [31:0]       rdata;
    logic [1:0]        err_code, dbg_state;

    load_store_unit_if #(.ADDR_W(ADDR_W)) mem_bus ();

    load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err),
        .err_code    (err_code),
        .dbg_state   (dbg_state),
        .mem         (mem_bus.master)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_rdata = 32'd0;
    logic [33:0] exp_q[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return 1 << int'(f3[1:0]);
    endfunction

    function automatic logic [1:0] ref_fault(input logic we, input logic [2:0] f3,
                                             input logic [ADDR_W-1:0] a);
        if (we ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2'b10;
        if ((int'(a) % size_of(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [ADDR_W-1:0] a);
        return 4'(((1 << size_of(f3)) - 1) << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
        if (size_of(f3) == 1) return (w & 32'hFF) * 32'h0101_0101;
        if (size_of(f3) == 2) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                                             input logic [31:0] word);
        longint v;
        v = longint'(word >> (8 * int'(a[1:0])));
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'd4: v = v % 256;
            3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'd5: v = v % 65536;
            default: v = longint'(word);
        endcase
        return 32'(v);
    endfunction

    // ---------------- driver: one full access, checked phase by phase ----------------
    // k = wait cycles before mem_ready; k >= TO means memory never answers.
    task automatic access(input logic we, input logic [2:0] f3, input logic [ADDR_W-1:0] a,
                          input logic [31:0] wd, input int k, input logic [31:0] word,
                          input string tag);
        logic [1:0]  code;
        logic [31:0] prev, erd;
        logic [33:0] exp;
        int          nbusy;
        prev = model_rdata;
        code = ref_fault(we, f3, a);
        erd  = prev;
        if (code == 2'b00 && k >= TO) code = 2'b11;
        if (code == 2'b11) erd = 32'd0;
        else if (code == 2'b00 && !we) erd = ref_load(f3, a, word);
        model_rdata = erd;
        exp_q.push_back({code, erd});

        req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
        mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = $urandom;
        #1;
        vectors++;
        if ({stall, mem_bus.mem_req, rdata_valid, err, rdata} !== {4'b1000, prev}) begin
            miscompares++;
            $display("FAIL %s_idle got stall/req/rv/err/rdata=%b%b%b%b/%h exp 1000/%h",
                     tag, stall, mem_bus.mem_req, rdata_valid, err, rdata, prev);
        end
        @(posedge clk); @(negedge clk);

        if (code != 2'b10 && code != 2'b01) begin
            nbusy = (k < TO) ? k + 1 : TO;
            for (int i = 0; i < nbusy; i++) begin
                vectors++;
                if ({stall, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_be} !==
                    {1'b1, 1'b1, we, a & 16'hFFFC, ref_be(f3, a)}) begin
                    miscompares++;
                    $display("FAIL %s_busy%0d got st/req/we/addr/be=%b%b%b/%h/%b exp 11%b/%h/%b",
                             tag, i, stall, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr,
                             mem_bus.mem_be, we, a & 16'hFFFC, ref_be(f3, a));
                end
                if (we) begin
                    vectors++;
                    if (mem_bus.mem_wdata !== ref_wdata(f3, wd)) begin
                        miscompares++;
                        $display("FAIL %s_wdata%0d got %h exp %h",
                                 tag, i, mem_bus.mem_wdata, ref_wdata(f3, wd));
                    end
                end
                mem_bus.mem_ready = (i == k);
                mem_bus.mem_rdata = (i == k) ? word : $urandom;
                @(posedge clk); @(negedge clk);
            end
        end

        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = $urandom;
        exp = exp_q.pop_front();
        vectors++;
        if ({stall, mem_bus.mem_req, rdata_valid, err, err_code, rdata} !==
            {1'b0, 1'b0, !we && exp[33:32] == 2'b00, exp[33:32] != 2'b00, exp[33:32], exp[31:0]}) begin
            miscompares++;
            $display("FAIL %s_done got st/req/rv/err/code/rdata=%b%b%b%b/%b/%h exp code %b rdata %h",
                     tag, stall, mem_bus.mem_req, rdata_valid, err, err_code, rdata,
                     exp[33:32], exp[31:0]);
        end
        // The core advances here; whatever it presents in DONE must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        funct3    = 3'($urandom_range(0, 7));
        addr      = ADDR_W'($urandom);
        @(posedge clk); @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = '0; wdata = 32'd0;
        mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = 32'd0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({stall, rdata_valid, err, err_code, rdata, mem_bus.mem_req, mem_bus.mem_we,
             mem_bus.mem_addr, mem_bus.mem_be, mem_bus.mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset got st=%b rv=%b err=%b code=%b rdata=%h req=%b be=%b exp all 0",
                     stall, rdata_valid, err, err_code, rdata, mem_bus.mem_req, mem_bus.mem_be);
        end
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        model_rdata = 32'd0;
    endtask

    task automatic test_lw_basic;
        access(1'b0, 3'b010, 16'h0010, 32'd0, 0, 32'hDEAD_BEEF, "lw_basic");
    endtask

    task automatic test_byte_loads;
        access(1'b0, 3'b000, 16'h0013, 32'd0, 0, 32'h80FF_7F01, "lb");
        access(1'b0, 3'b100, 16'h0013, 32'd0, 1, 32'h80FF_7F01, "lbu");
        access(1'b0, 3'b001, 16'h0012, 32'd0, 0, 32'h80FF_7F01, "lh");
        access(1'b0, 3'b101, 16'h0012, 32'd0, 2, 32'h80FF_7F01, "lhu");
    endtask

    task automatic test_sh_wait;
        access(1'b1, 3'b001, 16'h0022, 32'h1234_ABCD, 3, 32'd0, "sh_wait");
        access(1'b1, 3'b000, 16'h0031, 32'h0000_005A, 0, 32'd0, "sb");
    endtask

    task automatic test_faults;
        access(1'b0, 3'b010, 16'h0006, 32'd0, 0, 32'd0, "lw_misalign");
        access(1'b1, 3'b100, 16'h0040, 32'h1111_2222, 0, 32'd0, "st_illegal");
        access(1'b1, 3'b101, 16'h0041, 32'h1111_2222, 0, 32'd0, "illegal_first");
        access(1'b0, 3'b101, 16'h0043, 32'd0, 0, 32'd0, "lhu_misalign");
    endtask

    task automatic test_timeout;
        access(1'b0, 3'b010, 16'h0080, 32'd0, TO + 10, 32'h1234_5678, "timeout");
        access(1'b0, 3'b010, 16'h0084, 32'd0, TO - 1, 32'hCAFE_F00D, "last_chance");
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010; addr = 16'h0040; wdata = $urandom;
        mem_bus.mem_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        vectors++;
        if ({mem_bus.mem_req, stall} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_mid_busy got req/stall=%b%b exp 11", mem_bus.mem_req, stall);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({mem_bus.mem_req, stall, err, rdata_valid, rdata} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_async got req/stall/err/rv=%b%b%b%b rdata=%h exp 0",
                     mem_bus.mem_req, stall, err, rdata_valid, rdata);
        end
        model_rdata = 32'd0;
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        access(1'b0, 3'b010, 16'h0044, 32'd0, 1, 32'h0BAD_F00D, "post_reset_lw");
    endtask

    task automatic test_random;
        logic [2:0] f3;
        int         k;
        for (int n = 0; n < 80; n++) begin
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                             : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1 && f3 inside {3'd0, 3'd1}) f3 = f3 | 3'b100;
            k  = ($urandom_range(0, 12) == 0) ? TO + int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, 4));
            access(1'($urandom_range(0, 1)), f3, ADDR_W'($urandom), $urandom, k, $urandom,
                   "random");
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_lw_basic();
        test_byte_loads();
        test_sh_wait();
        test_faults();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
